// File: rtl/b2r_pkg.sv
// b2r_converter shared package: derived geometry, counter widths
// and the elaboration-time parameter legality check.
package b2r_pkg;

    // Input beats needed to fill one block-row strip
    function automatic int b2r_bps(int col, int bs, int nc);
        return col / (bs * nc);
    endfunction

    // Block-row strips per matrix
    function automatic int b2r_strips(int row, int bs);
        return row / bs;
    endfunction

    // Counter width for a 0..n-1 range, never narrower than one bit
    function automatic int b2r_cw(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // True when the geometry tiles exactly into blocks and beats
    function automatic bit b2r_params_ok(int row, int col, int bs,
                                         int cs, int nc);
        if (bs < 1 || nc < 1)
            return 1'b0;
        return (row % bs == 0) && (col % (bs * nc) == 0) &&
               (cs == bs * bs);
    endfunction

endpackage

// File: rtl/b2r_if.sv
// b2r_converter bus: block-beat input handshake plus row output
// handshake. master = producer/consumer side, slave = converter.
interface b2r_if #(
    parameter int WIDTH      = 16,
    parameter int COL        = 6,
    parameter int CHUNK_SIZE = 4,
    parameter int NUM_CORES  = 1
);
    logic                                  en;
    logic                                  in_ready;
    logic [WIDTH*CHUNK_SIZE*NUM_CORES-1:0] in_b2r_buffer;
    logic [WIDTH*COL-1:0]                  out_b2r_buffer;
    logic                                  out_valid;
    logic                                  out_ready;
    logic                                  row_last;
    logic                                  buffer_done;

    modport master (
        output en, in_b2r_buffer, out_ready,
        input  in_ready, out_b2r_buffer, out_valid, row_last, buffer_done
    );

    modport slave (
        input  en, in_b2r_buffer, out_ready,
        output in_ready, out_b2r_buffer, out_valid, row_last, buffer_done
    );
endinterface

// File: rtl/b2r_strip_bank.sv
// b2r_strip_bank: one block-row strip (BLOCK_SIZE rows x COL elements),
// written a beat of NUM_CORES blocks at a time, read a full row at a time.
module b2r_strip_bank
    import b2r_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int COL        = 6,
    parameter int BLOCK_SIZE = 2,
    parameter int CHUNK_SIZE = 4,
    parameter int NUM_CORES  = 1,
    localparam int BPS = b2r_bps(COL, BLOCK_SIZE, NUM_CORES),
    localparam int BW  = b2r_cw(BPS),
    localparam int RW  = b2r_cw(BLOCK_SIZE)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  we,
    input  logic [BW-1:0]                         wr_beat,
    input  logic [WIDTH*CHUNK_SIZE*NUM_CORES-1:0] wr_data,
    input  logic [RW-1:0]                         rd_row,
    output logic [WIDTH*COL-1:0]                  rd_data
);
    localparam int CIW = b2r_cw(COL);
    localparam int NE  = CHUNK_SIZE * NUM_CORES;

    logic [WIDTH-1:0] mem [BLOCK_SIZE][COL];

    // Scatter each chunk (row-major, core 0 in the MS slice) into its columns
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BLOCK_SIZE; i++)
                for (int c = 0; c < COL; c++)
                    mem[i][c] <= '0;
        end else if (we) begin
            for (int k = 0; k < NUM_CORES; k++)
                for (int e = 0; e < CHUNK_SIZE; e++)
                    mem[RW'(e / BLOCK_SIZE)]
                       [CIW'(int'(wr_beat) * NUM_CORES * BLOCK_SIZE +
                             k * BLOCK_SIZE + e % BLOCK_SIZE)]
                        <= wr_data[(NE - k * CHUNK_SIZE - e) * WIDTH - 1 -: WIDTH];
        end
    end

    // Present the selected row with column 0 in the MS slice
    always_comb begin
        rd_data = '0;
        for (int c = 0; c < COL; c++)
            rd_data[(COL - c) * WIDTH - 1 -: WIDTH] = mem[rd_row][c];
    end

endmodule

// File: rtl/b2r_converter.sv
// b2r_converter: block-row-major result blocks in, full matrix rows out,
// ping-pong strip banks. B2R_OUT_REG_EN adds a registered output stage.
module b2r_converter
    import b2r_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int ROW        = 8,
    parameter int COL        = 6,
    parameter int BLOCK_SIZE = 2,
    parameter int CHUNK_SIZE = 4,
    parameter int NUM_CORES  = 1
) (
    input logic clk,
    input logic rst_n,
    b2r_if.slave bus
);
    localparam int BPS = b2r_bps(COL, BLOCK_SIZE, NUM_CORES);
    localparam int BW  = b2r_cw(BPS);
    localparam int RW  = b2r_cw(BLOCK_SIZE);
    localparam int OW  = b2r_cw(ROW);

    localparam logic [BW-1:0] BEAT_LAST = BW'(BPS - 1);
    localparam logic [RW-1:0] SUB_LAST  = RW'(BLOCK_SIZE - 1);
    localparam logic [OW-1:0] ROW_LAST  = OW'(ROW - 1);

    if (!b2r_params_ok(ROW, COL, BLOCK_SIZE, CHUNK_SIZE, NUM_CORES))
    begin : g_bad_params
        $error("b2r_converter: ROW/COL/BLOCK_SIZE/CHUNK_SIZE do not tile");
    end

    logic [BW-1:0]        wr_beat;
    logic                 wr_bank;
    logic [1:0]           bank_full;
    logic [RW-1:0]        rd_row;
    logic                 rd_bank;
    logic [OW-1:0]        out_row;
    logic                 done_q;

    logic                 accept;
    logic                 strip_in_done;
    logic                 strip_out_done;
    logic                 src_valid;
    logic                 src_last;
    logic                 pop;
    logic                 done_set;
    logic [WIDTH*COL-1:0] row0;
    logic [WIDTH*COL-1:0] row1;
    logic [WIDTH*COL-1:0] src_data;

    assign bus.in_ready   = rst_n & ~bank_full[wr_bank];
    assign accept         = bus.en & bus.in_ready;
    assign strip_in_done  = accept & (wr_beat == BEAT_LAST);
    assign src_valid      = bank_full[rd_bank];
    assign src_last       = (out_row == ROW_LAST);
    assign src_data       = rd_bank ? row1 : row0;
    assign strip_out_done = pop & (rd_row == SUB_LAST);
    assign bus.buffer_done = done_q;

    b2r_strip_bank #(
        .WIDTH(WIDTH), .COL(COL), .BLOCK_SIZE(BLOCK_SIZE),
        .CHUNK_SIZE(CHUNK_SIZE), .NUM_CORES(NUM_CORES)
    ) u_bank0 (
        .clk(clk), .rst_n(rst_n),
        .we(accept & ~wr_bank), .wr_beat(wr_beat),
        .wr_data(bus.in_b2r_buffer),
        .rd_row(rd_row), .rd_data(row0)
    );

    b2r_strip_bank #(
        .WIDTH(WIDTH), .COL(COL), .BLOCK_SIZE(BLOCK_SIZE),
        .CHUNK_SIZE(CHUNK_SIZE), .NUM_CORES(NUM_CORES)
    ) u_bank1 (
        .clk(clk), .rst_n(rst_n),
        .we(accept & wr_bank), .wr_beat(wr_beat),
        .wr_data(bus.in_b2r_buffer),
        .rd_row(rd_row), .rd_data(row1)
    );

`ifdef B2R_OUT_REG_EN
    logic [WIDTH*COL-1:0] q_data;
    logic                 q_valid;
    logic                 q_last;

    assign pop      = src_valid & (~q_valid | bus.out_ready);
    assign done_set = q_valid & q_last & bus.out_ready;

    assign bus.out_b2r_buffer = q_data;
    assign bus.out_valid      = q_valid;
    assign bus.row_last       = q_last;

    // One-entry output stage: refills whenever empty or being drained
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_data  <= '0;
            q_valid <= 1'b0;
            q_last  <= 1'b0;
        end else if (~q_valid | bus.out_ready) begin
            q_valid <= src_valid;
            q_last  <= src_valid & src_last;
            if (src_valid)
                q_data <= src_data;
        end
    end
`else
    assign pop      = src_valid & bus.out_ready;
    assign done_set = pop & src_last;

    assign bus.out_b2r_buffer = src_data;
    assign bus.out_valid      = src_valid;
    assign bus.row_last       = src_valid & src_last;
`endif

    // Write side: beat counter and fill-bank pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_beat <= '0;
            wr_bank <= 1'b0;
        end else if (accept) begin
            if (wr_beat == BEAT_LAST) begin
                wr_beat <= '0;
                wr_bank <= ~wr_bank;
            end else begin
                wr_beat <= wr_beat + 1'b1;
            end
        end
    end

    // Bank ownership: filled strip set full, drained strip released
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_full <= '0;
        end else begin
            if (strip_in_done)
                bank_full[wr_bank] <= 1'b1;
            if (strip_out_done)
                bank_full[rd_bank] <= 1'b0;
        end
    end

    // Read side: row within strip, drain-bank pointer, matrix row
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_row  <= '0;
            rd_bank <= 1'b0;
            out_row <= '0;
        end else if (pop) begin
            if (rd_row == SUB_LAST) begin
                rd_row  <= '0;
                rd_bank <= ~rd_bank;
            end else begin
                rd_row <= rd_row + 1'b1;
            end
            if (out_row == ROW_LAST)
                out_row <= '0;
            else
                out_row <= out_row + 1'b1;
        end
    end

    // End-of-matrix pulse, one cycle after the final row handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            done_q <= 1'b0;
        else
            done_q <= done_set;
    end

endmodule

// File: doc/b2r_converter.md
Name: b2r_converter

Overview:
- Downstream counterpart of the weight row-to-block converter, placed after the Multi-MAC cores.
- Consumes result blocks (BLOCK_SIZE x BLOCK_SIZE, NUM_CORES blocks per beat) in block-row-major order.
- Re-emits the ROW x COL matrix one full row per handshake.
- Uses two strip banks (ping-pong), so one block-row strip fills while the previous one drains.

Parameters:
- WIDTH, 16, element width (Q8.8).
- ROW, 8, matrix rows; must be a multiple of BLOCK_SIZE.
- COL, 6, matrix columns; must be a multiple of BLOCK_SIZE*NUM_CORES.
- BLOCK_SIZE, 2, block edge length.
- CHUNK_SIZE, 4, elements per block; must equal BLOCK_SIZE*BLOCK_SIZE.
- NUM_CORES, 1, blocks carried per input beat.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  input beat valid.
- in_ready  out  1  input beat accepted when en && in_ready.
- in_b2r_buffer  in  WIDTH*CHUNK_SIZE*NUM_CORES  NUM_CORES blocks; core 0 in the MS slice.
- out_b2r_buffer  out  WIDTH*COL  one matrix row; column 0 in the MS WIDTH bits.
- out_valid  out  1  row available.
- out_ready  in  1  downstream accepts the row.
- row_last  out  1  high with out_valid on matrix row ROW-1.
- buffer_done  out  1  one-cycle pulse after the final row handshake.

Behaviour:
- Derived constants:
  - BPS = COL/(BLOCK_SIZE*NUM_CORES) beats per strip.
  - STRIPS = ROW/BLOCK_SIZE.
- Input ordering:
  - Beat b of strip s carries blocks (s, b*NUM_CORES+k), k = 0..NUM_CORES-1.
  - Within a chunk, elements are row-major; element (0,0) sits in the MS WIDTH bits.
- Write side:
  - Counters wr_beat (0..BPS-1), wr_bank (0/1), flag bank_full[1:0].
  - in_ready = !bank_full[wr_bank].
  - Each accepted beat writes its blocks into bank wr_bank at column offset b*NUM_CORES*BLOCK_SIZE.
  - On the accept of beat BPS-1: set bank_full[wr_bank], toggle wr_bank, wr_beat returns to 0.
- Read side:
  - Counters rd_row (0..BLOCK_SIZE-1), rd_bank, and out_row (0..ROW-1).
  - out_valid = bank_full[rd_bank].
  - out_b2r_buffer = row rd_row of bank rd_bank, a mux of registered storage. It holds stable while out_valid && !out_ready.
  - On handshake: rd_row++ and out_row++.
  - On the handshake where rd_row = BLOCK_SIZE-1: clear bank_full[rd_bank], toggle rd_bank.
- Latency: the last beat of a strip accepted at cycle N gives out_valid at N+1.
- Throughput:
  - With out_ready held high and BPS >= BLOCK_SIZE, en may stay high continuously.
  - Otherwise in_ready throttles the input.
- Simultaneous set and clear in the same cycle always target different banks; both take effect.
- Matrix end:
  - The handshake with out_row = ROW-1 produces a buffer_done pulse next cycle.
  - All counters wrap to 0 and the next matrix follows with no gap.
- Reset, asserted at any time:
  - Counters, bank pointers and bank_full go to 0.
  - out_valid, row_last and buffer_done go to 0; out_b2r_buffer is all zeros.
  - in_ready is 0 while rst_n is low and 1 on the first cycle after release.
  - Partial strips are discarded.
- en while !in_ready is ignored; no state changes.

Optional Feature:
- Macro: B2R_OUT_REG_EN.
- Defined:
  - Adds a one-entry registered output stage (data, out_valid, row_last).
  - The stage loads when empty or being drained.
  - Latency becomes N+2; full throughput is preserved.
  - buffer_done is aligned to the registered final-row handshake.
- Undefined: the combinational mux output described above.

Decomposition:
- Package b2r_pkg holds:
  - functions computing BPS and STRIPS;
  - counter widths via $clog2;
  - a parameter-check function that flags illegal divisibility at elaboration.
- Sub-module b2r_strip_bank holds one strip: BLOCK_SIZE rows x COL elements.
  - Write port: beat index plus NUM_CORES chunks.
  - Read port: row index.
  - Instantiated twice.

Test Plan:
- Defaults, out_ready=1, 12 beats on cycles 0..11, element (r,c) = (r*6+c)*256:
  - First beat is 0000_0100_0600_0700.
  - Row 0 = 0000_0100_0200_0300_0400_0500 at cycle 3.
  - Row 1 = 0600_..._0b00 at cycle 4.
  - in_ready never drops.
- Same stimulus, tail of the matrix:
  - Row 7 = 2a00_2b00_2c00_2d00_2e00_2f00 with row_last=1 at cycle 13.
  - buffer_done pulses at cycle 14.
- out_ready=0 throughout:
  - in_ready falls after beat 5 (both banks full).
  - out_valid=1 and row 0 is held stable.
  - Releasing out_ready drains rows 0..3 in order.
- rst_n pulled low after 4 beats:
  - All outputs go to 0.
  - A fresh 12-beat matrix reproduces the first scenario exactly.
- NUM_CORES=3, COL=6 (BPS=1):
  - Each single beat yields two rows.
  - Row 0 appears one cycle after beat 0.
  - With continuous en, in_ready throttles to at most one beat per two cycles.
- Random en and out_ready over 3 matrices: the scoreboard sees all 24 rows in order, and buffer_done pulses exactly 3 times.
